// File: rtl/condlogic_if.sv
// condlogic_if: Execute-stage control bundle between decode/hazard logic and the condition unit
interface condlogic_if #(
  parameter int FLAG_GROUPS = 2,
  parameter int CNT_W = 16
);
  logic                   Stall;
  logic                   FlushE;
  logic                   ClrCount;
  logic                   ValidE;
  logic [3:0]             CondE;
  logic [3:0]             ALUFlags;
  logic [FLAG_GROUPS-1:0] FlagWE;
  logic                   PCSE;
  logic                   RegWE;
  logic                   MemWE;
  logic                   MemtoRegE;
  logic                   BranchE;
  logic                   CondExE;
  logic                   BranchTakenE;
  logic                   PCSrcM;
  logic                   RegWriteM;
  logic                   MemWriteM;
  logic                   MemtoRegM;
  logic                   UndefM;
  logic                   PCSrcW;
  logic                   RegWriteW;
  logic                   MemtoRegW;
  logic                   UndefW;
  logic [3:0]             Flags;
  logic [CNT_W-1:0]       AnnulCount;
  modport master (
    output Stall, FlushE, ClrCount, ValidE, CondE, ALUFlags, FlagWE,
           PCSE, RegWE, MemWE, MemtoRegE, BranchE,
    input  CondExE, BranchTakenE, PCSrcM, RegWriteM, MemWriteM, MemtoRegM, UndefM,
           PCSrcW, RegWriteW, MemtoRegW, UndefW, Flags, AnnulCount
  );
  modport slave (
    input  Stall, FlushE, ClrCount, ValidE, CondE, ALUFlags, FlagWE,
           PCSE, RegWE, MemWE, MemtoRegE, BranchE,
    output CondExE, BranchTakenE, PCSrcM, RegWriteM, MemWriteM, MemtoRegM, UndefM,
           PCSrcW, RegWriteW, MemtoRegW, UndefW, Flags, AnnulCount
  );
endinterface

// File: rtl/condlogic_pipe.sv
// condlogic_pipe: ARM condition evaluation with gated E->M->W controls, NZCV register and annul counter
module condlogic_pipe #(
  parameter int         FLAG_GROUPS = 2,
  parameter int         CNT_W       = 16,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input logic       clk,
  input logic       reset,
  condlogic_if.slave bus
);
  localparam int GW = 4 / FLAG_GROUPS;
  if (FLAG_GROUPS != 1 && FLAG_GROUPS != 2 && FLAG_GROUPS != 4) begin : g_bad_groups
    $error("condlogic_pipe: FLAG_GROUPS must be 1, 2 or 4");
  end
  logic       n, z, c, v, ge, cond, undef, live, annul;
  logic [7:0] base;
  logic [3:0] flags_nx;
  // Even codes select a base predicate and odd codes invert it; 111x is AL / undefined
  always_comb begin
    {n, z, c, v} = bus.Flags;
    ge = ~(n ^ v);
    base = {1'b1, ~z & ge, ge, c & ~z, v, n, c, z};
    undef = &bus.CondE;
    cond = (&bus.CondE[3:1]) ? ~bus.CondE[0] : base[bus.CondE[3:1]] ^ bus.CondE[0];
    live = bus.ValidE & ~bus.FlushE & ~bus.Stall;
    annul = live & ~cond & (bus.PCSE | bus.RegWE | bus.MemWE | (|bus.FlagWE));
    flags_nx = bus.Flags;
    for (int i = 0; i < FLAG_GROUPS; i++)
      if (live & cond & bus.FlagWE[i]) flags_nx[i*GW +: GW] = bus.ALUFlags[i*GW +: GW];
  end
  assign bus.CondExE = cond;
  assign bus.BranchTakenE = bus.BranchE & cond & live;
  // Architectural NZCV only moves on advancing edges so a stalled instruction sees stable flags
  always_ff @(posedge clk)
    if (reset) bus.Flags <= RESET_FLAGS;
    else if (!bus.Stall) bus.Flags <= flags_nx;
  // M takes gated controls or a bubble; W follows M; both freeze under stall
  always_ff @(posedge clk)
    if (reset) begin
      {bus.PCSrcM, bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM, bus.UndefM} <= '0;
      {bus.PCSrcW, bus.RegWriteW, bus.MemtoRegW, bus.UndefW} <= '0;
    end else if (!bus.Stall) begin
      {bus.PCSrcM, bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM, bus.UndefM} <= live ?
        {bus.PCSE & cond, bus.RegWE & cond, bus.MemWE & cond, bus.MemtoRegE, undef} : 5'b0;
      {bus.PCSrcW, bus.RegWriteW, bus.MemtoRegW, bus.UndefW} <=
        {bus.PCSrcM, bus.RegWriteM, bus.MemtoRegM, bus.UndefM};
    end
  // Saturating count of live instructions whose side effects were suppressed
  always_ff @(posedge clk)
    if (reset) bus.AnnulCount <= '0;
    else if (!bus.Stall) begin
      if (bus.ClrCount) bus.AnnulCount <= '0;
      else if (annul && !(&bus.AnnulCount)) bus.AnnulCount <= bus.AnnulCount + CNT_W'(1);
    end
endmodule

// File: tb/tb_condlogic_pipe.sv
// tb_condlogic_pipe: randomized and directed check of condlogic_pipe against a behavioural model
module tb_condlogic_pipe;
  logic clk = 0;
  logic rst = 1;
  logic stall = 0, flush = 0, clr = 0, valid = 0;
  logic [3:0] cond = 0, alu = 0;
  logic [1:0] fwe = 0;
  logic pcs = 0, rwe = 0, mwe = 0, m2r = 0, br = 0;
  int n_chk = 0, n_pass = 0;
  logic [3:0] m_flags;
  logic [4:0] m_m;
  logic [3:0] m_w;
  int m_cnt, m_cnt2;
  always #5 clk = ~clk;
  condlogic_if #(.FLAG_GROUPS(2), .CNT_W(16)) bus ();
  condlogic_if #(.FLAG_GROUPS(2), .CNT_W(2)) bus2 ();
  assign {bus.Stall, bus.FlushE, bus.ClrCount, bus.ValidE} = {stall, flush, clr, valid};
  assign {bus.CondE, bus.ALUFlags, bus.FlagWE} = {cond, alu, fwe};
  assign {bus.PCSE, bus.RegWE, bus.MemWE, bus.MemtoRegE, bus.BranchE} = {pcs, rwe, mwe, m2r, br};
  assign {bus2.Stall, bus2.FlushE, bus2.ClrCount, bus2.ValidE} = {stall, flush, clr, valid};
  assign {bus2.CondE, bus2.ALUFlags, bus2.FlagWE} = {cond, alu, fwe};
  assign {bus2.PCSE, bus2.RegWE, bus2.MemWE, bus2.MemtoRegE, bus2.BranchE} = {pcs, rwe, mwe, m2r, br};
  condlogic_pipe #(.FLAG_GROUPS(2), .CNT_W(16), .RESET_FLAGS(4'b0100)) dut (.clk(clk), .reset(rst), .bus(bus));
  condlogic_pipe #(.FLAG_GROUPS(2), .CNT_W(2), .RESET_FLAGS(4'b0100)) dut2 (.clk(clk), .reset(rst), .bus(bus2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !(c && !z);
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && n == v;
      4'hD: return !(!z && n == v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_flags = 4'b0100;
    m_m = 0;
    m_w = 0;
    m_cnt = 0;
    m_cnt2 = 0;
  endtask

  task automatic cyc();
    logic ce, live, annul;
    @(negedge clk);
    ce = cond_ok(cond, m_flags);
    live = valid && !flush && !stall;
    chk("condex", bus.CondExE, ce);
    chk("brtaken", bus.BranchTakenE, br && ce && live);
    chk("flags", bus.Flags, m_flags);
    chk("m_ctl", {bus.PCSrcM, bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM, bus.UndefM}, m_m);
    chk("w_ctl", {bus.PCSrcW, bus.RegWriteW, bus.MemtoRegW, bus.UndefW}, m_w);
    chk("annul", bus.AnnulCount, m_cnt);
    chk("annul_sat", bus2.AnnulCount, m_cnt2);
    if (rst) model_reset();
    else if (!stall) begin
      annul = live && !ce && (pcs || rwe || mwe || fwe != 0);
      for (int b = 0; b < 4; b++) if (live && ce && fwe[b / 2]) m_flags[b] = alu[b];
      m_w = {m_m[4], m_m[3], m_m[1], m_m[0]};
      m_m = live ? {pcs && ce, rwe && ce, mwe && ce, m2r, cond == 4'hF} : 5'b0;
      if (clr) begin
        m_cnt = 0;
        m_cnt2 = 0;
      end else if (annul) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {stall, flush, clr, valid, pcs, rwe, mwe, m2r, br} = '0;
    fwe = 0;
    alu = 0;
    cond = 4'hE;
  endtask

  task automatic set_flags(input logic [3:0] f);
    idle();
    valid = 1;
    fwe = 2'b11;
    alu = f;
    cyc();
    idle();
  endtask

  initial begin
    int c0;
    int sat[5] = '{1, 2, 3, 3, 3};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_flags", bus.Flags, 4'b0100);
    chk("rst_m", {bus.PCSrcM, bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM, bus.UndefM}, 0);
    chk("rst_cnt", bus.AnnulCount, 0);
    idle();
    valid = 1;
    cond = 4'h0;
    rwe = 1;
    cyc();
    chk("eq_regwrite_m", bus.RegWriteM, 1);
    idle();
    cyc();
    chk("eq_regwrite_w", bus.RegWriteW, 1);
    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      for (int cc = 0; cc < 16; cc++) begin
        cond = 4'(cc);
        cyc();
      end
    end
    idle();
    valid = 1;
    rwe = 1;
    cond = 4'hF;
    cyc();
    chk("undef_m", bus.UndefM, 1);
    chk("undef_regwrite", bus.RegWriteM, 0);
    set_flags(4'b0000);
    valid = 1;
    alu = 4'b1111;
    fwe = 2'b10;
    cyc();
    chk("grp_hi", bus.Flags, 4'b1100);
    fwe = 2'b01;
    cyc();
    chk("grp_lo", bus.Flags, 4'b1111);
    c0 = m_cnt;
    cond = 4'h1;
    cyc();
    chk("ne_hold", bus.Flags, 4'b1111);
    chk("ne_annul", bus.AnnulCount, c0 + 1);
    set_flags(4'b0100);
    valid = 1;
    cond = 4'h0;
    rwe = 1;
    fwe = 2'b11;
    alu = 4'b0000;
    stall = 1;
    repeat (3) cyc();
    chk("stall_flags", bus.Flags, 4'b0100);
    stall = 0;
    cyc();
    chk("adds_flags", bus.Flags, 4'b0000);
    chk("adds_regwrite", bus.RegWriteM, 1);
    idle();
    c0 = m_cnt;
    valid = 1;
    rwe = 1;
    mwe = 1;
    flush = 1;
    cyc();
    chk("flush_bubble", {bus.RegWriteM, bus.MemWriteM}, 0);
    chk("flush_cnt", bus.AnnulCount, c0);
    stall = 1;
    cyc();
    idle();
    clr = 1;
    cyc();
    idle();
    valid = 1;
    rwe = 1;
    cond = 4'hF;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("sat_seq", bus2.AnnulCount, sat[k]);
    end
    clr = 1;
    cyc();
    chk("clr_wins", bus2.AnnulCount, 0);
    idle();
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 63) == 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 15) == 0);
      valid = ($urandom_range(0, 4) != 0);
      cond = 4'($urandom_range(0, 15));
      alu = 4'($urandom_range(0, 15));
      fwe = 2'($urandom_range(0, 3));
      {pcs, rwe, mwe, m2r, br} = 5'($urandom_range(0, 31));
      cyc();
    end
    rst = 0;
    idle();
    cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
